// File: rtl/nthband_reconstructor.sv
// rtl/nthband_reconstructor.sv - joins prediction/residual streams into xhat samples and per-block xhat means
// Optional saturation of the reconstructed sample: NTHBAND_RECONSTRUCTOR_CLAMP_EN
module nthband_reconstructor #(
    parameter int DATA_WIDTH     = 16,
    parameter int BLOCK_SIZE_LOG = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    prediction_valid,
    output logic                    prediction_ready,
    input  logic [DATA_WIDTH:0]     prediction_data,

    input  logic                    error_valid,
    output logic                    error_ready,
    input  logic [DATA_WIDTH:0]     error_data,

    output logic                    xhat_valid,
    input  logic                    xhat_ready,
    output logic [DATA_WIDTH-1:0]   xhat_data,

    output logic                    xhatmean_valid,
    input  logic                    xhatmean_ready,
    output logic [DATA_WIDTH-1:0]   xhatmean_data
);

    localparam int SUM_W = DATA_WIDTH + 2;
    localparam int ACC_W = DATA_WIDTH + BLOCK_SIZE_LOG;

    logic [BLOCK_SIZE_LOG-1:0] sample_cnt;
    logic [ACC_W-1:0]          acc;
    logic signed [SUM_W-1:0]   sum;
    logic [DATA_WIDTH-1:0]     xhat_next;
    logic [ACC_W-1:0]          acc_sum;
    logic                      last_sample;
    logic                      sample_free;
    logic                      mean_free;
    logic                      can_accept;
    logic                      accept;

    // Both operands are sign-extended by one bit so the add can never overflow.
    assign sum = $signed({prediction_data[DATA_WIDTH], prediction_data})
               + $signed({error_data[DATA_WIDTH], error_data});

`ifdef NTHBAND_RECONSTRUCTOR_CLAMP_EN
    always_comb begin
        xhat_next = sum[DATA_WIDTH-1:0];
        if (sum[SUM_W-1]) begin
            xhat_next = '0;
        end else if (sum[DATA_WIDTH]) begin
            xhat_next = '1;
        end
    end
`else
    logic sum_hi_unused;
    assign sum_hi_unused = ^sum[SUM_W-1:DATA_WIDTH];
    assign xhat_next     = sum[DATA_WIDTH-1:0];
`endif

    assign last_sample = (sample_cnt == {BLOCK_SIZE_LOG{1'b1}});
    assign sample_free = !xhat_valid || xhat_ready;
    assign mean_free   = !xhatmean_valid || xhatmean_ready;

    // The closing sample of a block also needs room in the mean register.
    assign can_accept = rst && sample_free && (!last_sample || mean_free);

    assign accept           = prediction_valid && error_valid && can_accept;
    assign prediction_ready = can_accept && error_valid;
    assign error_ready      = can_accept && prediction_valid;

    assign acc_sum = acc + {{BLOCK_SIZE_LOG{1'b0}}, xhat_next};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xhat_valid     <= 1'b0;
            xhat_data      <= '0;
            xhatmean_valid <= 1'b0;
            xhatmean_data  <= '0;
            sample_cnt     <= '0;
            acc            <= '0;
        end else begin
            if (accept) begin
                xhat_valid <= 1'b1;
                xhat_data  <= xhat_next;
                sample_cnt <= sample_cnt + 1'b1;
            end else if (xhat_ready) begin
                xhat_valid <= 1'b0;
            end

            if (accept && last_sample) begin
                xhatmean_valid <= 1'b1;
                xhatmean_data  <= acc_sum[ACC_W-1:BLOCK_SIZE_LOG];
                acc            <= '0;
            end else begin
                if (xhatmean_ready) begin
                    xhatmean_valid <= 1'b0;
                end
                if (accept) begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_nthband_reconstructor.sv
// tb/tb_nthband_reconstructor.sv - directed and model-checked bench for nthband_reconstructor
module tb_nthband_reconstructor;

    localparam int W = 16;
    localparam int L = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          prediction_valid, prediction_ready;
    logic [W:0]    prediction_data;
    logic          error_valid, error_ready;
    logic [W:0]    error_data;
    logic          xhat_valid, xhat_ready;
    logic [W-1:0]  xhat_data;
    logic          xhatmean_valid, xhatmean_ready;
    logic [W-1:0]  xhatmean_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nthband_reconstructor #(.DATA_WIDTH(W), .BLOCK_SIZE_LOG(L)) dut (
        .clk              (clk),
        .rst              (rst),
        .prediction_valid (prediction_valid),
        .prediction_ready (prediction_ready),
        .prediction_data  (prediction_data),
        .error_valid      (error_valid),
        .error_ready      (error_ready),
        .error_data       (error_data),
        .xhat_valid       (xhat_valid),
        .xhat_ready       (xhat_ready),
        .xhat_data        (xhat_data),
        .xhatmean_valid   (xhatmean_valid),
        .xhatmean_ready   (xhatmean_ready),
        .xhatmean_data    (xhatmean_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offers one joined sample and returns one cycle after it is accepted.
    task automatic push(input logic [W:0] p, input logic [W:0] e, input string tag);
        logic ok;
        ok = 1'b0;
        prediction_data  = p;
        error_data       = e;
        prediction_valid = 1'b1;
        error_valid      = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = prediction_ready && error_ready;
            @(posedge clk);
            #1;
        end
        prediction_valid = 1'b0;
        error_valid      = 1'b0;
        if (!ok) chk({tag, "_accept_timeout"}, 32'(ok), 32'd1);
    endtask

    function automatic logic [W-1:0] model_xhat(input logic [W:0] p, input logic [W:0] e);
        int s;
        s = int'($signed(p)) + int'($signed(e));
`ifdef NTHBAND_RECONSTRUCTOR_CLAMP_EN
        if (s < 0) return '0;
        if (s > 65535) return 16'hFFFF;
`endif
        return s[W-1:0];
    endfunction

    logic [W-1:0] exp_a [4];
    logic [W-1:0] xq [$];
    logic [W-1:0] mq [$];
    logic [W:0]   p_cur, e_cur;
    logic [W-1:0] xv;
    int           macc, mcnt, n_in, n_x, n_m;

    initial begin
        rst              = 1'b0;
        prediction_valid = 1'b1;
        error_valid      = 1'b1;
        prediction_data  = '0;
        error_data       = '0;
        xhat_ready       = 1'b1;
        xhatmean_ready   = 1'b1;

        // reset state
        #12;
        chk("rst_pred_ready", 32'(prediction_ready), 0);
        chk("rst_err_ready", 32'(error_ready), 0);
        chk("rst_xhat_valid", 32'(xhat_valid), 0);
        chk("rst_mean_valid", 32'(xhatmean_valid), 0);
        chk("rst_xhat_data", 32'(xhat_data), 0);
        chk("rst_mean_data", 32'(xhatmean_data), 0);
        rst              = 1'b1;
        prediction_valid = 1'b0;
        error_valid      = 1'b0;
        @(posedge clk);
        #1;

        // basic block, full throughput
        exp_a[0] = 101; exp_a[1] = 198; exp_a[2] = 303; exp_a[3] = 396;
        push(17'd100, 17'd1, "blk1_s0");
        chk("blk1_x0", 32'(xhat_data), 32'(exp_a[0]));
        chk("blk1_mv0", 32'(xhatmean_valid), 0);
        push(17'd200, -17'sd2, "blk1_s1");
        chk("blk1_x1", 32'(xhat_data), 32'(exp_a[1]));
        push(17'd300, 17'd3, "blk1_s2");
        chk("blk1_x2", 32'(xhat_data), 32'(exp_a[2]));
        chk("blk1_mv2", 32'(xhatmean_valid), 0);
        push(17'd400, -17'sd4, "blk1_s3");
        chk("blk1_xv3", 32'(xhat_valid), 1);
        chk("blk1_x3", 32'(xhat_data), 32'(exp_a[3]));
        chk("blk1_mv3", 32'(xhatmean_valid), 1);
        chk("blk1_mean", 32'(xhatmean_data), 249);

        // overflow/underflow sums
        push(17'd65535, 17'd10, "ovf");
`ifdef NTHBAND_RECONSTRUCTOR_CLAMP_EN
        chk("ovf_xhat", 32'(xhat_data), 65535);
`else
        chk("ovf_xhat", 32'(xhat_data), 9);
`endif
        chk("ovf_mv_cleared", 32'(xhatmean_valid), 0);
        push(17'd5, -17'sd20, "udf");
`ifdef NTHBAND_RECONSTRUCTOR_CLAMP_EN
        chk("udf_xhat", 32'(xhat_data), 0);
`else
        chk("udf_xhat", 32'(xhat_data), 65521);
`endif

        // residual stream starved: nothing may be accepted
        prediction_data  = 17'd777;
        prediction_valid = 1'b1;
        error_valid      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("starve_pred_ready", 32'(prediction_ready), 0);
            chk("starve_xhat_valid", 32'(xhat_valid), 0);
        end
        push(17'd1000, 17'd0, "blk2_s2");
        chk("blk2_x2", 32'(xhat_data), 1000);
        push(17'd2000, 17'd0, "blk2_s3");
        chk("blk2_x3", 32'(xhat_data), 2000);
        chk("blk2_mv", 32'(xhatmean_valid), 1);
`ifdef NTHBAND_RECONSTRUCTOR_CLAMP_EN
        chk("blk2_mean", 32'(xhatmean_data), 17133);
`else
        chk("blk2_mean", 32'(xhatmean_data), 17132);
`endif
        @(posedge clk);
        #1;
        chk("blk2_mv_clear", 32'(xhatmean_valid), 0);
        chk("blk2_xv_clear", 32'(xhat_valid), 0);

        // mean backpressure stalls the closing sample of the next block
        xhatmean_ready = 1'b0;
        push(17'd10, 17'd0, "bpa_s0");
        push(17'd20, 17'd0, "bpa_s1");
        push(17'd30, 17'd0, "bpa_s2");
        push(17'd40, 17'd0, "bpa_s3");
        chk("bpa_mean", 32'(xhatmean_data), 25);
        push(17'd1, 17'd0, "bpb_s0");
        chk("bpb_x0", 32'(xhat_data), 1);
        push(17'd2, 17'd0, "bpb_s1");
        push(17'd3, 17'd0, "bpb_s2");
        chk("bpb_x2", 32'(xhat_data), 3);
        prediction_data  = 17'd100;
        error_data       = 17'd0;
        prediction_valid = 1'b1;
        error_valid      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_pred_ready", 32'(prediction_ready), 0);
            chk("bp_err_ready", 32'(error_ready), 0);
            chk("bp_mean_hold", 32'(xhatmean_data), 25);
        end
        @(posedge clk);
        #1;
        xhatmean_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(prediction_ready), 1);
        @(posedge clk);
        #1;
        prediction_valid = 1'b0;
        error_valid      = 1'b0;
        chk("bpb_mv", 32'(xhatmean_valid), 1);
        chk("bpb_mean", 32'(xhatmean_data), 26);
        chk("bpb_x3", 32'(xhat_data), 100);
        @(posedge clk);
        #1;
        chk("bpb_mv_clear", 32'(xhatmean_valid), 0);

        // reset in the middle of a block discards the partial block
        push(17'd500, 17'd0, "mid_s0");
        push(17'd700, 17'd0, "mid_s1");
        rst              = 1'b0;
        prediction_valid = 1'b1;
        error_valid      = 1'b1;
        #2;
        chk("mid_rst_xv", 32'(xhat_valid), 0);
        chk("mid_rst_mv", 32'(xhatmean_valid), 0);
        chk("mid_rst_pr", 32'(prediction_ready), 0);
        chk("mid_rst_er", 32'(error_ready), 0);
        @(posedge clk);
        #1;
        rst              = 1'b1;
        prediction_valid = 1'b0;
        error_valid      = 1'b0;
        push(17'd4, 17'd0, "post_s0");
        push(17'd8, 17'd0, "post_s1");
        push(17'd12, 17'd0, "post_s2");
        chk("post_mv2", 32'(xhatmean_valid), 0);
        push(17'd16, 17'd0, "post_s3");
        chk("post_mv3", 32'(xhatmean_valid), 1);
        chk("post_mean", 32'(xhatmean_data), 10);
        @(posedge clk);
        #1;

        // random output backpressure against a software model
        macc  = 0; mcnt = 0; n_in = 0; n_x = 0; n_m = 0;
        p_cur = 17'($urandom);
        e_cur = 17'($urandom);
        for (int cyc = 0; cyc < 20000 && (n_x < 1024 || n_m < 256); cyc++) begin
            xhat_ready       = 1'($urandom_range(0, 1));
            xhatmean_ready   = ($urandom_range(0, 3) != 0);
            prediction_valid = (n_in < 1024);
            error_valid      = (n_in < 1024);
            prediction_data  = p_cur;
            error_data       = e_cur;
            @(negedge clk);
            if (prediction_valid && error_valid && prediction_ready && error_ready) begin
                xv = model_xhat(p_cur, e_cur);
                xq.push_back(xv);
                macc += int'(xv);
                mcnt++;
                if (mcnt == 4) begin
                    mq.push_back(16'(macc / 4));
                    macc = 0;
                    mcnt = 0;
                end
                n_in++;
                p_cur = 17'($urandom);
                e_cur = 17'($urandom);
            end
            if (xhat_valid && xhat_ready) begin
                if (xq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL rand_xhat_extra observed=%0d expected=none", xhat_data);
                end else begin
                    chk("rand_xhat", 32'(xhat_data), 32'(xq.pop_front()));
                end
                n_x++;
            end
            if (xhatmean_valid && xhatmean_ready) begin
                if (mq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL rand_mean_extra observed=%0d expected=none", xhatmean_data);
                end else begin
                    chk("rand_mean", 32'(xhatmean_data), 32'(mq.pop_front()));
                end
                n_m++;
            end
            @(posedge clk);
            #1;
        end
        prediction_valid = 1'b0;
        error_valid      = 1'b0;
        chk("rand_in_count", 32'(n_in), 1024);
        chk("rand_xhat_count", 32'(n_x), 1024);
        chk("rand_mean_count", 32'(n_m), 256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
